// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD MAC/nonlinear datapath and its issue scheduler.
package simd_pkg;

   // Operand width of one MAC lane.
   localparam int MAC_BW      = 8;

   // Default datapath latencies (issue to result) for the MAC and nonlinear modes.
   localparam int LAT_MAC_DEF = 2;
   localparam int LAT_NL_DEF  = 3;

   // Datapath mode select; MODE_MAC uses the short pipeline, the others the long one.
   typedef enum logic [1:0] {
      MODE_MAC = 2'b00,
      MODE_NL0 = 2'b01,
      MODE_NL1 = 2'b10,
      MODE_NL2 = 2'b11
   } simd_mode_t;

   // Scheduler FSM; encoding 2'b11 is unused and recovers to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_DRAIN = 2'b01,
      ST_ISSUE = 2'b10
   } sched_state_t;

endpackage

// File: rtl/sched_credit_cnt.sv
// Credit counter for the downstream result buffer: one credit is spent per issued
// beat and returned per consumed result. A return while already full is dropped
// and latches a sticky error flag.
module sched_credit_cnt
   import simd_pkg::*;
#(
   parameter int CREDITS = 4,
   parameter int CW      = $clog2(CREDITS + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic dec_i,
   output logic zero_o,
   output logic err_o
);

   localparam logic [CW-1:0] CNT_FULL = CW'(CREDITS);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   assign zero_o = (cnt_q == CNT_ZERO);
   assign err_o  = err_q;

   // Next credit count and error flag; simultaneous spend and return cancel out.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      case ({inc_i, dec_i})
         2'b01: begin
            cnt_d = cnt_q - CNT_ONE;
         end
         2'b10: begin
            if (cnt_q == CNT_FULL) begin
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   // Credit and error registers; reset refills the buffer credits and clears the error.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= CNT_FULL;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule

// File: rtl/simd_mac_sched.sv
// Issue scheduler for the 64-lane SIMD MAC/nonlinear datapath. Accepts one job at a
// time, gates operand beats into the datapath under a credit limit, tracks beats in
// flight to tag results with valid/last, and drains the pipeline before any mode
// change so the shared demux/mux never switches under live data.
module simd_mac_sched
   import simd_pkg::*;
#(
   parameter int LAT_MAC = LAT_MAC_DEF,
   parameter int LAT_NL  = LAT_NL_DEF,
   parameter int BEATS_W = 8,
   parameter int CREDITS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [1:0]         job_mode,
   input  logic [BEATS_W-1:0] job_beats,
   input  logic               op_valid,
   output logic               op_ready,
   output logic               arr_en,
   output logic [1:0]         arr_mode,
   output logic               res_valid,
   output logic               res_last,
   output logic               job_done,
   input  logic               res_pop,
   output logic               busy,
   output logic               err
);

   localparam logic [BEATS_W-1:0] BEATS_ZERO = {BEATS_W{1'b0}};
   localparam logic [BEATS_W-1:0] BEATS_ONE  = BEATS_W'(1);
   localparam logic [LAT_NL-1:0]  PIPE_ZERO  = {LAT_NL{1'b0}};

   sched_state_t       state_q, state_d;
   simd_mode_t         mode_q, mode_d;
   simd_mode_t         pend_mode_q, pend_mode_d;
   logic [BEATS_W-1:0] rem_q, rem_d;
   logic [LAT_NL-1:0]  vld_q, vld_d;
   logic [LAT_NL-1:0]  lst_q, lst_d;

   simd_mode_t job_mode_s;
   logic       mac_mode_s;
   logic       pipe_empty_s;
   logic       cred_zero_s;
   logic       issue_s;

   assign job_mode_s   = simd_mode_t'(job_mode);
   assign mac_mode_s   = (mode_q == MODE_MAC);
   assign pipe_empty_s = (vld_q == PIPE_ZERO);

   // Handshakes: op_ready drops in the same cycle the credit register reaches zero.
   assign job_ready = (state_q == ST_IDLE);
   assign op_ready  = (state_q == ST_ISSUE) && !cred_zero_s;
   assign issue_s   = op_valid && op_ready;
   assign arr_en    = issue_s;
   assign arr_mode  = mode_q;

   // Result tags come from the tap matching the current mode's latency.
   assign res_valid = mac_mode_s ? vld_q[LAT_MAC-1] : vld_q[LAT_NL-1];
   assign res_last  = mac_mode_s ? lst_q[LAT_MAC-1] : lst_q[LAT_NL-1];
   assign job_done  = res_valid && res_last;
   assign busy      = (state_q != ST_IDLE) || !pipe_empty_s;

   sched_credit_cnt #(
      .CREDITS (CREDITS)
   ) u_credit (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (res_pop),
      .dec_i  (issue_s),
      .zero_o (cred_zero_s),
      .err_o  (err)
   );

   // Job FSM: accept in IDLE, wait out in-flight beats before a mode switch, then issue.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      pend_mode_d = pend_mode_q;
      rem_d       = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (job_valid && (job_beats != BEATS_ZERO)) begin
               rem_d = job_beats;
               if ((job_mode_s != mode_q) && !pipe_empty_s) begin
                  pend_mode_d = job_mode_s;
                  state_d     = ST_DRAIN;
               end else begin
                  mode_d  = job_mode_s;
                  state_d = ST_ISSUE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (pipe_empty_s) begin
               mode_d  = pend_mode_q;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_ISSUE: begin
            if (issue_s) begin
               rem_d = rem_q - BEATS_ONE;
               if (rem_q == BEATS_ONE) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_ISSUE;
               end
            end else begin
               state_d = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // In-flight tracker: shift valid/last toward the tap; stages past the MAC tap stay
   // clear in MAC mode so the pipeline reads empty as soon as the last result is out.
   always_comb begin
      vld_d    = PIPE_ZERO;
      lst_d    = PIPE_ZERO;
      vld_d[0] = issue_s;
      lst_d[0] = issue_s && (rem_q == BEATS_ONE);
      for (int i = 1; i < LAT_NL; i++) begin
         if (mac_mode_s && (i >= LAT_MAC)) begin
            vld_d[i] = 1'b0;
            lst_d[i] = 1'b0;
         end else begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
         end
      end
   end

   // State registers; reset discards every in-flight beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_MAC;
         pend_mode_q <= MODE_MAC;
         rem_q       <= BEATS_ZERO;
         vld_q       <= PIPE_ZERO;
         lst_q       <= PIPE_ZERO;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         pend_mode_q <= pend_mode_d;
         rem_q       <= rem_d;
         vld_q       <= vld_d;
         lst_q       <= lst_d;
      end
   end

endmodule
